// File: rtl/nn_accel_pkg.sv
// Shared types and sizes for the row-chunk image link into the digit-classifier accelerator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package nn_accel_pkg;

  localparam int IMG_BITS   = 196;
  localparam int CHUNK_W    = 7;
  localparam int NUM_CHUNKS = 28;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    GAP         = 2'd1,
    SEND        = 2'd2,
    WAIT_RESULT = 2'd3
  } tx_state_t;

  typedef logic [CHUNK_W-1:0] chunk_t;
  typedef logic [3:0]         bcd_t;

endpackage

// File: rtl/image_stream_tx_shift_reg.sv
// Image shadow register that walks the image out one chunk at a time.
// Latency: load visible on chunk_o the cycle after load_i; each shift_i edge advances one chunk.
// Backpressure: none; the caller decides when to shift.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : parallel-load image_i (takes priority over shift_i)
//   shift_i    : shift right by STEP bits
//   image_i    : W-bit image to capture
//   chunk_o    : low STEP bits of the register (current chunk)
module image_shift_reg #(
  parameter int W    = nn_accel_pkg::IMG_BITS,
  parameter int STEP = nn_accel_pkg::CHUNK_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            shift_i,
  input  logic [W-1:0]    image_i,
  output logic [STEP-1:0] chunk_o
);

  logic [W-1:0] sr_q, sr_d;

  // Shifting instead of indexing keeps the chunk select a fixed bit slice.
  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = image_i;
    end else if (shift_i) begin
      sr_d = sr_q >> STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign chunk_o = sr_q[STEP-1:0];

endmodule

// File: rtl/image_stream_tx.sv
// Transmit side of the row-chunk image link: send a 196-bit image as 28 chunks, then await the BCD result.
// Latency: chunk k on data_o after edge GAP_CYCLES+1+k from the start-accept edge; result visible the cycle after complete_i.
// Backpressure: none on the link; start_i is ignored while busy_o is high.
//
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   start_i, image_i        : send request and image (bit 7k+j = chunk k bit j)
//   busy_o                  : high from the cycle after accept until back in IDLE
//   data_o, frame_o         : chunk and frame flag to the receiver (frame low resets it)
//   complete_i, bcd_i       : receiver done flag and digit
//   result_valid_o/_bcd_o   : sticky captured result, cleared on next accepted start
//   timeout_o               : one-cycle pulse when the result wait expires
// Optional build macro IMG_STREAM_TIMEOUT_EN: bounds WAIT_RESULT to TIMEOUT_CYCLES cycles.
// Without it timeout_o is constant 0 and the block waits for complete_i indefinitely.
module image_stream_tx #(
  parameter int CHUNK_W        = 7,
  parameter int NUM_CHUNKS     = 28,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_i,
  input  logic [CHUNK_W*NUM_CHUNKS-1:0] image_i,
  output logic                          busy_o,
  output logic [CHUNK_W-1:0]            data_o,
  output logic                          frame_o,
  input  logic                          complete_i,
  input  logic [3:0]                    bcd_i,
  output logic                          result_valid_o,
  output logic [3:0]                    result_bcd_o,
  output logic                          timeout_o
);

  import nn_accel_pkg::*;

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
  localparam logic [4:0]       CHUNK_LAST = 5'(NUM_CHUNKS - 1);

  tx_state_t            state_q, state_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic [4:0]           chunk_cnt_q, chunk_cnt_d;
  logic                 frame_q, frame_d;
  logic [CHUNK_W-1:0]   data_q, data_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  bcd_t                 bcd_q, bcd_d;
  logic                 timeout_q, timeout_d;
  logic                 sr_load, sr_shift;
  logic [CHUNK_W-1:0]   sr_chunk;

`ifdef IMG_STREAM_TIMEOUT_EN
  localparam logic [10:0] TO_LAST = 11'(TIMEOUT_CYCLES - 1);
  logic [10:0] to_cnt_q, to_cnt_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  image_shift_reg #(
    .W    (CHUNK_W*NUM_CHUNKS),
    .STEP (CHUNK_W)
  ) u_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (sr_load),
    .shift_i (sr_shift),
    .image_i (image_i),
    .chunk_o (sr_chunk)
  );

  always_comb begin
    state_d     = state_q;
    gap_cnt_d   = gap_cnt_q;
    chunk_cnt_d = chunk_cnt_q;
    frame_d     = 1'b0;
    data_d      = '0;
    valid_d     = valid_q;
    bcd_d       = bcd_q;
    timeout_d   = 1'b0;
    sr_load     = 1'b0;
    sr_shift    = 1'b0;
`ifdef IMG_STREAM_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          sr_load   = 1'b1;
          valid_d   = 1'b0;
          gap_cnt_d = '0;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = SEND;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      SEND: begin
        // Outputs are registered, so the chunk seen on data_o lags the SEND edge by one cycle.
        frame_d  = 1'b1;
        data_d   = sr_chunk;
        sr_shift = 1'b1;
        if (chunk_cnt_q == CHUNK_LAST) begin
          chunk_cnt_d = '0;
          state_d     = WAIT_RESULT;
        end else begin
          chunk_cnt_d = chunk_cnt_q + 1'b1;
        end
      end
      WAIT_RESULT: begin
        // Keep frame high: dropping it would wipe the receiver before it answers.
        frame_d = 1'b1;
        if (complete_i) begin
          bcd_d   = bcd_i;
          valid_d = 1'b1;
          frame_d = 1'b0;
          state_d = IDLE;
`ifdef IMG_STREAM_TIMEOUT_EN
          to_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          frame_d   = 1'b0;
          to_cnt_d  = '0;
          state_d   = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gap_cnt_q   <= '0;
      chunk_cnt_q <= '0;
      frame_q     <= 1'b0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      bcd_q       <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      chunk_cnt_q <= chunk_cnt_d;
      frame_q     <= frame_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      bcd_q       <= bcd_d;
      timeout_q   <= timeout_d;
    end
  end

`ifdef IMG_STREAM_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`endif

  assign busy_o         = busy_q;
  assign data_o         = data_q;
  assign frame_o        = frame_q;
  assign result_valid_o = valid_q;
  assign result_bcd_o   = bcd_q;
  assign timeout_o      = timeout_q;

endmodule
